// File: rtl/ram_responder.sv
// Big-endian byte-serial memory responder for the MOV/MOC handshake, one byte per clock.
// Optional misalignment trap is enabled with `define MISALIGN_CHECK_EN.
module ram_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        MOV,
  input  logic        RW,
  input  logic [1:0]  typeData,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        MOC,
  output logic        ERR,
  output logic [1:0]  state_dbg
);
  // Handshake: a request is captured on an edge with MOV=1 in IDLE (after MOV was seen
  // low in IDLE); MOC is held from DONE entry until an edge with MOV=0 returns to IDLE.
  localparam int AW = $clog2(DEPTH);
  localparam logic [15:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 16'(WAIT_CYCLES - 1) : 16'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          rw_q, rw_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   acc_q, acc_d;
  logic [31:0]   dout_q, dout_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [15:0]   wait_q, wait_d;
  logic          moc_q, moc_d;
  logic          err_q, err_d;
  logic          armed_q, armed_d;
  logic          mis_q, mis_d;

  logic          mis_req;
  logic [1:0]    n_m1;
  logic [31:0]   wdata_lj;
  logic [7:0]    rd_byte;
  logic          mem_we;
  logic          unused_addr_bits;

  logic [7:0]    mem [0:DEPTH-1];

  // Address wraps mod DEPTH (DEPTH is expected to be a power of two).
  assign unused_addr_bits = ^Address[31:AW];

`ifdef MISALIGN_CHECK_EN
  assign mis_req = (typeData == 2'b01 && Address[0]) ||
                   (typeData[1] && Address[1:0] != 2'b00);
`else
  assign mis_req = 1'b0;
`endif

  // Write data is left-justified at capture so byte i is always the top byte.
  always_comb begin
    n_m1     = 2'd3;
    wdata_lj = DataIn;
    case (typeData)
      2'b00: begin
        n_m1     = 2'd0;
        wdata_lj = {DataIn[7:0], 24'h0};
      end
      2'b01: begin
        n_m1     = 2'd1;
        wdata_lj = {DataIn[15:0], 16'h0};
      end
      default: begin
        n_m1     = 2'd3;
        wdata_lj = DataIn;
      end
    endcase
  end

  assign rd_byte = mem[addr_q];
  assign mem_we  = (state_q == S_XFER) && !rw_q && !mis_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    acc_d   = acc_q;
    dout_d  = dout_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    moc_d   = moc_q;
    err_d   = err_q;
    armed_d = armed_q;
    mis_d   = mis_q;
    case (state_q)
      S_IDLE: begin
        moc_d = 1'b0;
        if (!MOV) armed_d = 1'b1;
        if (MOV && armed_q) begin
          addr_d  = Address[AW-1:0];
          rw_d    = RW;
          wdata_d = wdata_lj;
          acc_d   = 32'h0;
          cnt_d   = n_m1;
          wait_d  = WAIT_INIT;
          armed_d = 1'b0;
          mis_d   = mis_req;
          // A trapped access skips the wait and spends its single edge in XFER.
          if (mis_req || WAIT_CYCLES == 0) state_d = S_XFER;
          else                             state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_q == 16'd0) state_d = S_XFER;
        else                 wait_d  = wait_q - 16'd1;
      end
      S_XFER: begin
        if (mis_q) begin
          state_d = S_DONE;
          moc_d   = 1'b1;
          err_d   = 1'b1;
          mis_d   = 1'b0;
        end else begin
          acc_d   = {acc_q[23:0], rd_byte};
          wdata_d = {wdata_q[23:0], 8'h0};
          addr_d  = addr_q + AW'(1);
          if (cnt_q == 2'd0) begin
            state_d = S_DONE;
            moc_d   = 1'b1;
            if (rw_q) dout_d = {acc_q[23:0], rd_byte};
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
      end
      S_DONE: begin
        if (!MOV) begin
          state_d = S_IDLE;
          moc_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= 32'h0;
      acc_q   <= 32'h0;
      dout_q  <= 32'h0;
      cnt_q   <= 2'd0;
      wait_q  <= 16'd0;
      moc_q   <= 1'b0;
      err_q   <= 1'b0;
      armed_q <= 1'b1;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      acc_q   <= acc_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      moc_q   <= moc_d;
      err_q   <= err_d;
      armed_q <= armed_d;
      mis_q   <= mis_d;
    end
  end

  // The array is never reset; a CLR edge suppresses the in-flight byte write.
  always_ff @(posedge CLK) begin
    if (!CLR && mem_we) mem[addr_q] <= wdata_q[31:24];
  end

  assign DataOut   = dout_q;
  assign MOC       = moc_q;
  assign ERR       = err_q;
  assign state_dbg = state_q;
endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: one instance with no wait states, one with WAIT_CYCLES=3.
module tb_ram_responder;
  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        mov = 1'b0;
  logic        mov_w = 1'b0;
  logic        rw = 1'b0;
  logic [1:0]  typ = 2'b00;
  logic [31:0] addr = 32'h0;
  logic [31:0] din = 32'h0;
  logic [31:0] dout, dout_w;
  logic        moc, moc_w, err, err_w;
  logic [1:0]  st, st_w;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ram_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut (
    .CLK(clk), .CLR(clr), .MOV(mov), .RW(rw), .typeData(typ), .Address(addr),
    .DataIn(din), .DataOut(dout), .MOC(moc), .ERR(err), .state_dbg(st)
  );

  ram_responder #(.DEPTH(256), .WAIT_CYCLES(3)) dut_w (
    .CLK(clk), .CLR(clr), .MOV(mov_w), .RW(rw), .typeData(typ), .Address(addr),
    .DataIn(din), .DataOut(dout_w), .MOC(moc_w), .ERR(err_w), .state_dbg(st_w)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b1;
    mov = 1'b0;
    mov_w = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
  endtask

  // One access: inputs are scrambled after the capture edge; lat counts edges from capture to MOC.
  task automatic run_access(input bit sel_w, input logic rw_i, input logic [1:0] t_i,
                            input logic [31:0] a_i, input logic [31:0] d_i, input int hold_edges,
                            output int lat, output bit err_at_done, output bit held_ok,
                            output bit fell);
    @(negedge clk);
    rw = rw_i; typ = t_i; addr = a_i; din = d_i;
    if (sel_w) mov_w = 1'b1;
    else       mov = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rw = ~rw_i; typ = ~t_i; addr = ~a_i; din = ~d_i;
    if (hold_edges == 0) begin
      mov = 1'b0;
      mov_w = 1'b0;
    end
    lat = -1;
    err_at_done = 1'b0;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(posedge clk);
      @(negedge clk);
      if ((sel_w ? moc_w : moc) === 1'b1) begin
        lat = i;
        err_at_done = sel_w ? err_w : err;
      end
    end
    held_ok = 1'b1;
    for (int i = 0; i < hold_edges; i++) begin
      @(posedge clk);
      @(negedge clk);
      if ((sel_w ? moc_w : moc) !== 1'b1) held_ok = 1'b0;
    end
    mov = 1'b0;
    mov_w = 1'b0;
    @(posedge clk);
    @(negedge clk);
    fell = ((sel_w ? moc_w : moc) === 1'b0);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    dut.mem[0] = 8'hE3;
    do_reset();
    total++; if (moc !== 1'b0) begin bad++; $display("FAIL reset_moc got=%b exp=0", moc); end
    total++; if (dout !== 32'h0) begin bad++; $display("FAIL reset_dout got=%h exp=0", dout); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    total++; if (st !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", st); end
    total++; if (dut.mem[0] !== 8'hE3) begin bad++; $display("FAIL reset_mem0 got=%h exp=e3", dut.mem[0]); end
    total++; if (moc_w !== 1'b0 || st_w !== 2'd0) begin bad++; $display("FAIL reset_w got=%b/%0d exp=0/0", moc_w, st_w); end
  endtask

  task automatic test_word_write();
    int lat; bit e, h, f;
    run_access(1'b0, 1'b0, 2'b10, 32'h0000_0010, 32'hDEADBEEF, 0, lat, e, h, f);
    total++; if (lat != 4) begin bad++; $display("FAIL ww_latency got=%0d exp=4", lat); end
    total++; if ({dut.mem[16], dut.mem[17], dut.mem[18], dut.mem[19]} !== 32'hDEADBEEF) begin
      bad++; $display("FAIL ww_mem got=%h exp=deadbeef", {dut.mem[16], dut.mem[17], dut.mem[18], dut.mem[19]});
    end
    total++; if (!f) begin bad++; $display("FAIL ww_moc_pulse got=stuck exp=fall"); end
    total++; if (dout !== 32'h0) begin bad++; $display("FAIL ww_dout_hold got=%h exp=0", dout); end
  endtask

  task automatic test_reads();
    int lat; bit e, h, f;
    run_access(1'b0, 1'b1, 2'b10, 32'hABCD_0010, 32'h0, 0, lat, e, h, f);
    total++; if (lat != 4 || dout !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_word got=%h lat=%0d exp=deadbeef lat=4", dout, lat); end
    run_access(1'b0, 1'b1, 2'b00, 32'h0000_0012, 32'hFFFF_FFFF, 0, lat, e, h, f);
    total++; if (lat != 1 || dout !== 32'h0000_00BE) begin bad++; $display("FAIL rd_byte got=%h lat=%0d exp=000000be lat=1", dout, lat); end
    run_access(1'b0, 1'b1, 2'b01, 32'h0000_0010, 32'h0, 0, lat, e, h, f);
    total++; if (lat != 2 || dout !== 32'h0000_DEAD) begin bad++; $display("FAIL rd_half got=%h lat=%0d exp=0000dead lat=2", dout, lat); end
    total++; if ({dut.mem[16], dut.mem[17], dut.mem[18], dut.mem[19]} !== 32'hDEADBEEF) begin
      bad++; $display("FAIL rd_mem_intact got=%h exp=deadbeef", {dut.mem[16], dut.mem[17], dut.mem[18], dut.mem[19]});
    end
    run_access(1'b0, 1'b0, 2'b00, 32'h0000_0040, 32'h1234_565A, 0, lat, e, h, f);
    total++; if (dut.mem[64] !== 8'h5A || dout !== 32'h0000_DEAD) begin
      bad++; $display("FAIL wr_byte got=mem %h dout %h exp=mem 5a dout 0000dead", dut.mem[64], dout);
    end
  endtask

  task automatic test_misaligned();
    int lat; bit e, h, f;
    run_access(1'b0, 1'b1, 2'b01, 32'h0000_0011, 32'h0, 0, lat, e, h, f);
`ifdef MISALIGN_CHECK_EN
    total++; if (lat != 1 || e !== 1'b1) begin bad++; $display("FAIL mis_trap got=lat %0d err %b exp=lat 1 err 1", lat, e); end
    total++; if (dout !== 32'h0000_DEAD) begin bad++; $display("FAIL mis_dout got=%h exp=0000dead", dout); end
`else
    total++; if (lat != 2 || e !== 1'b0) begin bad++; $display("FAIL mis_half got=lat %0d err %b exp=lat 2 err 0", lat, e); end
    total++; if (dout !== 32'h0000_ADBE) begin bad++; $display("FAIL mis_dout got=%h exp=0000adbe", dout); end
`endif
    total++; if (err !== 1'b0) begin bad++; $display("FAIL mis_err_clear got=%b exp=0", err); end
  endtask

  task automatic test_wrap();
    int lat; bit e, h, f;
    dut.mem[254] = 8'h00; dut.mem[255] = 8'h00; dut.mem[0] = 8'h00; dut.mem[1] = 8'h00;
    run_access(1'b0, 1'b0, 2'b10, 32'h0000_00FE, 32'h11223344, 0, lat, e, h, f);
`ifdef MISALIGN_CHECK_EN
    total++; if (lat != 1 || e !== 1'b1) begin bad++; $display("FAIL wrap_trap got=lat %0d err %b exp=lat 1 err 1", lat, e); end
    total++; if ({dut.mem[254], dut.mem[255], dut.mem[0], dut.mem[1]} !== 32'h0) begin
      bad++; $display("FAIL wrap_mem got=%h exp=00000000", {dut.mem[254], dut.mem[255], dut.mem[0], dut.mem[1]});
    end
`else
    total++; if (lat != 4) begin bad++; $display("FAIL wrap_latency got=%0d exp=4", lat); end
    total++; if ({dut.mem[254], dut.mem[255], dut.mem[0], dut.mem[1]} !== 32'h11223344) begin
      bad++; $display("FAIL wrap_mem got=%h exp=11223344", {dut.mem[254], dut.mem[255], dut.mem[0], dut.mem[1]});
    end
    run_access(1'b0, 1'b1, 2'b01, 32'h0000_01FF, 32'h0, 0, lat, e, h, f);
    total++; if (dout !== 32'h0000_2233) begin bad++; $display("FAIL wrap_read got=%h exp=00002233", dout); end
`endif
  endtask

  task automatic test_back_to_back();
    int lat; bit e, h, f;
    run_access(1'b0, 1'b1, 2'b11, 32'h0000_0010, 32'h0, 3, lat, e, h, f);
    total++; if (lat != 4 || dout !== 32'hDEADBEEF) begin bad++; $display("FAIL hold_read got=%h lat=%0d exp=deadbeef lat=4", dout, lat); end
    total++; if (!h) begin bad++; $display("FAIL hold_moc got=dropped exp=held"); end
    total++; if (!f || st !== 2'd0) begin bad++; $display("FAIL hold_release got=fell %b state %0d exp=fell 1 state 0", f, st); end
    run_access(1'b0, 1'b1, 2'b00, 32'h0000_0013, 32'h0, 0, lat, e, h, f);
    total++; if (lat != 1 || dout !== 32'h0000_00EF) begin bad++; $display("FAIL b2b_byte got=%h lat=%0d exp=000000ef lat=1", dout, lat); end
  endtask

  task automatic test_clr_abort();
    bit rose;
    dut.mem[32] = 8'h00; dut.mem[33] = 8'h00; dut.mem[34] = 8'h77; dut.mem[35] = 8'h88;
    @(negedge clk);
    rw = 1'b0; typ = 2'b10; addr = 32'h0000_0020; din = 32'hCAFEF00D; mov = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    mov = 1'b0;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    total++; if (st !== 2'd0 || dout !== 32'h0) begin bad++; $display("FAIL abort_state got=state %0d dout %h exp=state 0 dout 0", st, dout); end
    rose = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (moc !== 1'b0) rose = 1'b1;
    end
    total++; if (rose) begin bad++; $display("FAIL abort_moc got=rose exp=low"); end
    total++; if ({dut.mem[32], dut.mem[33], dut.mem[34], dut.mem[35]} !== 32'hCAFE7788) begin
      bad++; $display("FAIL abort_mem got=%h exp=cafe7788", {dut.mem[32], dut.mem[33], dut.mem[34], dut.mem[35]});
    end
  endtask

  task automatic test_wait();
    int lat; bit e, h, f;
    dut_w.mem[5] = 8'hA7;
    run_access(1'b1, 1'b1, 2'b00, 32'h0000_0005, 32'h0, 0, lat, e, h, f);
    total++; if (lat != 4) begin bad++; $display("FAIL wait_latency got=%0d exp=4", lat); end
    total++; if (dout_w !== 32'h0000_00A7 || err_w !== 1'b0) begin bad++; $display("FAIL wait_data got=%h err %b exp=000000a7 err 0", dout_w, err_w); end
    total++; if (!f || st_w !== 2'd0) begin bad++; $display("FAIL wait_release got=fell %b state %0d exp=fell 1 state 0", f, st_w); end
  endtask

  initial begin
    test_reset();
    test_word_write();
    test_reads();
    test_misaligned();
    test_wrap();
    test_back_to_back();
    test_clr_abort();
    test_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
